// File: rtl/dflow_pkg.sv
// rtl/dflow_pkg.sv - record layout and FSM encoding for the dflow QDR replay path
package dflow_pkg;

    // Stored record layout inside one 144-bit QDR word
    localparam int REC_VLD_BIT = 143;
    localparam int TUPLE_LSB   = 16;
    localparam int LEN_LSB     = 0;

    // Replay FSM encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CAL   = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/dflow_sync_fifo.sv
// rtl/dflow_sync_fifo.sv - show-ahead synchronous FIFO with occupancy count
module dflow_sync_fifo #(
    parameter int WIDTH = 120,
    parameter int DEPTH = 16
) (
    input  logic                       qdr_clk,
    input  logic                       resetn,
    input  logic                       wr_tvalid,
    input  logic [WIDTH-1:0]           wr_tdata,
    output logic                       rd_tvalid,
    input  logic                       rd_tready,
    output logic [WIDTH-1:0]           rd_tdata,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so push at full is legal alongside a pop
    assign do_pop    = rd_tready && (count != '0);
    assign do_push   = wr_tvalid && ((count != FULL_CNT) || do_pop);
    assign rd_tvalid = (count != '0);
    assign rd_tdata  = mem[rd_ptr];

    // Storage array, written only on an accepted push
    always_ff @(posedge qdr_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_tdata;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge qdr_clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dflow_qdr_replay_reader.sv
// rtl/dflow_qdr_replay_reader.sv - credit-limited QDR record replay reader
module dflow_qdr_replay_reader
    import dflow_pkg::*;
#(
    parameter int PKT_TUPLE_WIDTH = 104,
    parameter int PKT_LEN_WIDTH   = 16,
    parameter int QDR_ADDR_WIDTH  = 19,
    parameter int QDR_WORD_WIDTH  = 144,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                        qdr_clk,
    input  logic                        resetn,
    input  logic                        sw_rst,
    input  logic                        start_replay,
    input  logic                        stop_replay,
    input  logic                        loop_en,
    input  logic [QDR_ADDR_WIDTH-1:0]   mem_addr_low,
    input  logic [QDR_ADDR_WIDTH-1:0]   mem_addr_high,
    input  logic                        init_calib_complete,
    output logic                        user_app_rd_cmd,
    output logic [QDR_ADDR_WIDTH-1:0]   user_app_rd_addr,
    input  logic                        user_app_rd_valid,
    input  logic [QDR_WORD_WIDTH-1:0]   user_app_rd_data,
    output logic [PKT_TUPLE_WIDTH-1:0]  fivetuple_data_out,
    output logic [PKT_LEN_WIDTH-1:0]    pkt_len_out,
    output logic                        tuple_out_vld,
    input  logic                        tuple_out_ready,
    output logic                        replay_busy,
    output logic                        replay_done,
    output logic                        range_err,
    output logic [31:0]                 rec_count
);

    localparam int RW = PKT_TUPLE_WIDTH + PKT_LEN_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                      rst_n_int;
    logic [2:0]                state;
    logic                      start_q;
    logic                      start_edge;
    logic [QDR_ADDR_WIDTH-1:0] addr;
    logic [CW-1:0]             outstanding;
    logic [CW-1:0]             fifo_count;
    logic [CW:0]               credit_used;
    logic                      has_credit;
    logic                      issue;
    logic                      accept;
    logic                      push;
    logic                      pop;
    logic                      fifo_vld;
    logic [RW-1:0]             fifo_dout;
    logic                      unused_rd_bits;

    // Soft reset behaves exactly like the board reset
    assign rst_n_int  = resetn && !sw_rst;
    assign start_edge = start_replay && !start_q;

    // Every issued read reserves a FIFO slot until it is popped, so returns can never overflow
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
    assign has_credit  = credit_used < (CW+1)'(FIFO_DEPTH);
    assign issue       = rst_n_int && (state == ST_ISSUE) && has_credit
                         && init_calib_complete && !stop_replay;

    // Returns with nothing outstanding are strays from before a reset and are dropped
    assign accept = user_app_rd_valid && (outstanding != '0);
    assign push   = accept && user_app_rd_data[REC_VLD_BIT];
    assign pop    = fifo_vld && tuple_out_ready;

    assign unused_rd_bits = ^user_app_rd_data[REC_VLD_BIT-1:RW];

    assign user_app_rd_cmd    = issue;
    assign user_app_rd_addr   = addr;
    assign tuple_out_vld      = fifo_vld;
    assign fivetuple_data_out = fifo_dout[TUPLE_LSB +: PKT_TUPLE_WIDTH];
    assign pkt_len_out        = fifo_dout[LEN_LSB +: PKT_LEN_WIDTH];
    assign replay_busy        = (state != ST_IDLE);
    assign replay_done        = (state == ST_DONE);

    dflow_sync_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_ret_fifo (
        .qdr_clk   (qdr_clk),
        .resetn    (rst_n_int),
        .wr_tvalid (push),
        .wr_tdata  (user_app_rd_data[LEN_LSB +: RW]),
        .rd_tvalid (fifo_vld),
        .rd_tready (tuple_out_ready),
        .rd_tdata  (fifo_dout),
        .count     (fifo_count)
    );

    // Outstanding reads: +1 per issue, -1 per accepted return
    always_ff @(posedge qdr_clk) begin
        if (!rst_n_int) begin
            outstanding <= '0;
        end else begin
            case ({issue, accept})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Delivered-record counter, restarted by each start edge
    always_ff @(posedge qdr_clk) begin
        if (!rst_n_int) begin
            start_q   <= 1'b0;
            rec_count <= '0;
        end else begin
            start_q <= start_replay;
            if ((state == ST_IDLE) && start_edge) begin
                rec_count <= '0;
            end else if (pop) begin
                rec_count <= rec_count + 32'd1;
            end
        end
    end

    // Replay sequencing and read address walk over [low, high]
    always_ff @(posedge qdr_clk) begin
        if (!rst_n_int) begin
            state     <= ST_IDLE;
            addr      <= '0;
            range_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        range_err <= 1'b0;
                        state     <= ST_CAL;
                    end
                end
                ST_CAL: begin
                    if (mem_addr_low > mem_addr_high) begin
                        range_err <= 1'b1;
                        state     <= ST_DONE;
                    end else if (init_calib_complete) begin
                        addr  <= mem_addr_low;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (stop_replay) begin
                        state <= ST_DRAIN;
                    end else if (issue) begin
                        if (addr == mem_addr_high) begin
                            if (loop_en) begin
                                addr <= mem_addr_low;
                            end else begin
                                state <= ST_DRAIN;
                            end
                        end else begin
                            addr <= addr + QDR_ADDR_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((outstanding == '0) && !fifo_vld) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dflow_qdr_replay_reader.sv
// tb/tb_dflow_qdr_replay_reader.sv - self-checking bench for dflow_qdr_replay_reader
module tb_dflow_qdr_replay_reader;

    logic         qdr_clk = 1'b0;
    logic         resetn = 1'b0;
    logic         sw_rst = 1'b0;
    logic         start_replay = 1'b0;
    logic         stop_replay = 1'b0;
    logic         loop_en = 1'b0;
    logic [18:0]  mem_addr_low = '0;
    logic [18:0]  mem_addr_high = '0;
    logic         init_calib_complete = 1'b1;
    logic         user_app_rd_cmd;
    logic [18:0]  user_app_rd_addr;
    logic         user_app_rd_valid = 1'b0;
    logic [143:0] user_app_rd_data = '0;
    logic [103:0] fivetuple_data_out;
    logic [15:0]  pkt_len_out;
    logic         tuple_out_vld;
    logic         tuple_out_ready = 1'b1;
    logic         replay_busy;
    logic         replay_done;
    logic         range_err;
    logic [31:0]  rec_count;

    always #5 qdr_clk = ~qdr_clk;

    dflow_qdr_replay_reader dut (
        .qdr_clk             (qdr_clk),
        .resetn              (resetn),
        .sw_rst              (sw_rst),
        .start_replay        (start_replay),
        .stop_replay         (stop_replay),
        .loop_en             (loop_en),
        .mem_addr_low        (mem_addr_low),
        .mem_addr_high       (mem_addr_high),
        .init_calib_complete (init_calib_complete),
        .user_app_rd_cmd     (user_app_rd_cmd),
        .user_app_rd_addr    (user_app_rd_addr),
        .user_app_rd_valid   (user_app_rd_valid),
        .user_app_rd_data    (user_app_rd_data),
        .fivetuple_data_out  (fivetuple_data_out),
        .pkt_len_out         (pkt_len_out),
        .tuple_out_vld       (tuple_out_vld),
        .tuple_out_ready     (tuple_out_ready),
        .replay_busy         (replay_busy),
        .replay_done         (replay_done),
        .range_err           (range_err),
        .rec_count           (rec_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Memory contents: every address holds a distinct record; bad_addr marks one invalid record
    logic [19:0] bad_addr = 20'hFFFFF;

    function automatic logic [143:0] mem_word(input logic [18:0] a);
        logic [103:0] t;
        logic [15:0]  l;
        logic         v;
        t = {a, 8'hA5, 77'(a) * 77'd40503 + 77'd1};
        l = 16'(a) + 16'd64;
        v = ({1'b0, a} != bad_addr);
        return {v, 23'h5AA5A5, t, l};
    endfunction

    typedef struct {
        logic [18:0] a;
        int          due;
    } pend_t;

    pend_t        pend[$];
    logic [119:0] buf_q[$];
    int           cyc = 0;
    int           inflight = 0;
    int           stale = 0;
    int           popped = 0;
    int           n_cmd = 0;
    int           n_done = 0;
    int           done_e = 0;
    logic [18:0]  exp_addr = '0;
    logic [18:0]  last_addr = '0;
    logic [15:0]  first_len = '0;
    logic         first_arm = 1'b0;
    logic         prev_done = 1'b0;
    logic         start_prev = 1'b0;

    always @(posedge qdr_clk) cyc++;

    // QDR model: each read returns its word 6 cycles after the command edge
    always @(negedge qdr_clk) begin
        if (pend.size() > 0 && pend[0].due == cyc + 1) begin
            user_app_rd_valid = 1'b1;
            user_app_rd_data  = mem_word(pend[0].a);
            void'(pend.pop_front());
        end else begin
            user_app_rd_valid = 1'b0;
            user_app_rd_data  = '0;
        end
    end

    // Reference model and per-cycle compare, sampled just before each active edge
    always @(negedge qdr_clk) begin
        pend_t p;
        int    e;
        #4;
        e = cyc + 1;
        if (!resetn || sw_rst) begin
            chk("rst_cmd", user_app_rd_cmd, 1'b0);
            if (user_app_rd_valid) begin
                if (stale > 0) stale--;
                else inflight--;
            end
            stale    += inflight;
            inflight  = 0;
            buf_q.delete();
            popped    = 0;
            prev_done = 1'b0;
        end else begin
            chk("vld", tuple_out_vld, buf_q.size() > 0);
            if (tuple_out_vld && buf_q.size() > 0) begin
                chk("tuple", fivetuple_data_out, buf_q[0][119:16]);
                chk("len", pkt_len_out, buf_q[0][15:0]);
            end
            chk("rec_count", rec_count, popped);
            if (user_app_rd_cmd) begin
                chk("credit", (inflight + buf_q.size()) < 16, 1'b1);
                chk("cmd_gate", init_calib_complete && !stop_replay, 1'b1);
                chk("rd_addr", user_app_rd_addr, exp_addr);
                p.a = user_app_rd_addr;
                p.due = e + 6;
                pend.push_back(p);
                inflight++;
                n_cmd++;
                last_addr = user_app_rd_addr;
                exp_addr = (exp_addr == mem_addr_high) ? mem_addr_low : exp_addr + 19'd1;
            end
            if (tuple_out_vld && tuple_out_ready && buf_q.size() > 0) begin
                if (first_arm) begin
                    first_len = pkt_len_out;
                    first_arm = 1'b0;
                end
                void'(buf_q.pop_front());
                popped++;
            end
            if (user_app_rd_valid) begin
                if (stale > 0) begin
                    stale--;
                end else begin
                    inflight--;
                    if (user_app_rd_data[143]) buf_q.push_back(user_app_rd_data[119:0]);
                end
            end
            if (start_replay && !start_prev) popped = 0;
            if (replay_done) begin
                chk("done_1cyc", prev_done, 1'b0);
                n_done++;
                done_e = e;
            end
            prev_done = replay_done;
        end
        start_prev = start_replay;
    end

    int base_cmd;
    int base_done;
    int start_e;

    task automatic start_run(input logic [18:0] lo, input logic [18:0] hi, input logic lp);
        @(negedge qdr_clk);
        mem_addr_low  = lo;
        mem_addr_high = hi;
        loop_en       = lp;
        exp_addr      = lo;
        base_cmd      = n_cmd;
        base_done     = n_done;
        first_arm     = 1'b1;
        start_e       = cyc + 1;
        start_replay  = 1'b1;
        @(negedge qdr_clk);
        start_replay  = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        for (int i = 0; i < budget && replay_busy; i++) @(negedge qdr_clk);
        chk(nm, replay_busy, 1'b0);
        @(negedge qdr_clk);
    endtask

    task automatic wait_cmds(input int n, input int budget);
        for (int i = 0; i < budget && (n_cmd - base_cmd) < n; i++) @(negedge qdr_clk);
    endtask

    initial begin
        repeat (3) @(negedge qdr_clk);
        resetn = 1'b1;
        @(negedge qdr_clk);
        chk("rst_rd_cmd", user_app_rd_cmd, 1'b0);
        chk("rst_rd_addr", user_app_rd_addr, 19'd0);
        chk("rst_vld", tuple_out_vld, 1'b0);
        chk("rst_busy", replay_busy, 1'b0);
        chk("rst_done", replay_done, 1'b0);
        chk("rst_range_err", range_err, 1'b0);
        chk("rst_rec_count", rec_count, 32'd0);

        // 1: plain pass 0..7, calibration arrives late
        init_calib_complete = 1'b0;
        start_run(19'd0, 19'd7, 1'b0);
        repeat (3) @(negedge qdr_clk);
        chk("t1_cal_wait_cmds", n_cmd - base_cmd, 0);
        init_calib_complete = 1'b1;
        wait_idle("t1_timeout", 200);
        chk("t1_cmds", n_cmd - base_cmd, 8);
        chk("t1_rec_count", rec_count, 32'd8);
        chk("t1_done_pulses", n_done - base_done, 1);
        chk("t1_first_len", first_len, 16'h0040);
        chk("t1_last_addr", last_addr, 19'd7);

        // 2: consumer stalled, range 0..63 -> credit caps reads at 16
        tuple_out_ready = 1'b0;
        start_run(19'd0, 19'd63, 1'b0);
        repeat (60) @(negedge qdr_clk);
        chk("t2_stall_cmds", n_cmd - base_cmd, 16);
        chk("t2_stall_vld", tuple_out_vld, 1'b1);
        chk("t2_stall_inflight", inflight, 0);
        tuple_out_ready = 1'b1;
        wait_idle("t2_timeout", 600);
        chk("t2_cmds", n_cmd - base_cmd, 64);
        chk("t2_rec_count", rec_count, 32'd64);

        // 3: single-word looping range, stopped after 10 issues
        start_run(19'd5, 19'd5, 1'b1);
        wait_cmds(10, 200);
        stop_replay = 1'b1;
        wait_idle("t3_timeout", 200);
        stop_replay = 1'b0;
        chk("t3_cmds", n_cmd - base_cmd, 10);
        chk("t3_rec_count", rec_count, 32'd10);
        chk("t3_done_pulses", n_done - base_done, 1);

        // 4: record 3 invalid
        bad_addr = 20'd3;
        start_run(19'd0, 19'd7, 1'b0);
        wait_idle("t4_timeout", 200);
        bad_addr = 20'hFFFFF;
        chk("t4_cmds", n_cmd - base_cmd, 8);
        chk("t4_rec_count", rec_count, 32'd7);

        // 5: inverted range
        start_run(19'd9, 19'd4, 1'b0);
        wait_idle("t5_timeout", 50);
        chk("t5_cmds", n_cmd - base_cmd, 0);
        chk("t5_range_err", range_err, 1'b1);
        chk("t5_done_delay", done_e - start_e, 2);
        chk("t5_done_pulses", n_done - base_done, 1);

        // 6: soft reset with four reads outstanding
        start_run(19'd0, 19'd63, 1'b0);
        for (int i = 0; i < 50 && inflight < 4; i++) @(negedge qdr_clk);
        chk("t6_inflight", inflight, 4);
        sw_rst = 1'b1;
        @(negedge qdr_clk);
        sw_rst = 1'b0;
        chk("t6_stale", stale, 4);
        chk("t6_rd_cmd", user_app_rd_cmd, 1'b0);
        chk("t6_rd_addr", user_app_rd_addr, 19'd0);
        chk("t6_vld", tuple_out_vld, 1'b0);
        chk("t6_busy", replay_busy, 1'b0);
        chk("t6_range_err", range_err, 1'b0);
        chk("t6_rec_count", rec_count, 32'd0);
        for (int i = 0; i < 30 && stale > 0; i++) @(negedge qdr_clk);
        chk("t6_strays_seen", stale, 0);
        @(negedge qdr_clk);
        chk("t6_post_vld", tuple_out_vld, 1'b0);
        chk("t6_post_rec_count", rec_count, 32'd0);
        start_run(19'd0, 19'd7, 1'b0);
        wait_idle("t6_timeout", 200);
        chk("t6_rec_count_again", rec_count, 32'd8);

        // 7: top-of-memory wrap with a calibration dropout
        start_run(19'h7FFFE, 19'h7FFFF, 1'b1);
        wait_cmds(2, 100);
        init_calib_complete = 1'b0;
        repeat (3) @(negedge qdr_clk);
        chk("t7_pause_cmds", n_cmd - base_cmd, 2);
        chk("t7_pause_busy", replay_busy, 1'b1);
        init_calib_complete = 1'b1;
        wait_cmds(5, 100);
        stop_replay = 1'b1;
        wait_idle("t7_timeout", 200);
        stop_replay = 1'b0;
        chk("t7_cmds", n_cmd - base_cmd, 5);
        chk("t7_last_addr", last_addr, 19'h7FFFE);
        chk("t7_rec_count", rec_count, 32'd5);

        repeat (5) @(negedge qdr_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
